// File: rtl/spi_cmd_framer.sv
// rtl/spi_cmd_framer.sv - assembles SPI receive bytes into register commands
// Read frames are one address byte; write frames add a 17-bit little-endian payload.
module spi_cmd_framer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        sysClk,
  input  logic        sysRst_n,
  input  logic        spi_cs_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic        reg_busy,
  output logic [7:0]  reg_addr,
  output logic [16:0] reg_data,
  output logic        reg_input_valid,
  output logic        frame_error,
  output logic        cmd_overflow,
  output logic        frame_active
);

  typedef enum logic [1:0] {IDLE, D0, D1, D2} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      addr_q;
  logic [7:0]      lo_q;
  logic [7:0]      hi_q;
  logic [TO_W-1:0] to_cnt;
  logic            slot_full;
  logic [7:0]      slot_addr;
  logic [16:0]     slot_data;

  logic            byte_ok;
  logic            expire;
  logic            emit;
  logic            done;
  logic            abort;
  logic [7:0]      done_addr;
  logic [16:0]     done_data;

  // A byte arriving on the expiry cycle wins; a cs_n rise beats any byte.
  always_comb begin
    byte_ok   = rx_byte_valid && !spi_cs_n;
    expire    = (to_cnt == TO_LAST);
    emit      = slot_full && !reg_busy;
    done      = 1'b0;
    abort     = 1'b0;
    done_addr = addr_q;
    done_data = {rx_byte[0], hi_q, lo_q};
    case (state)
      IDLE: begin
        if (byte_ok && !rx_byte[7]) begin
          done      = 1'b1;
          done_addr = rx_byte;
          done_data = '0;
        end
      end
      D2: begin
        if (spi_cs_n)
          abort = 1'b1;
        else if (byte_ok) begin
          if (rx_byte[7:1] != 7'd0)
            abort = 1'b1;
          else
            done = 1'b1;
        end else if (expire)
          abort = 1'b1;
      end
      default: begin
        if (spi_cs_n || (!byte_ok && expire))
          abort = 1'b1;
      end
    endcase
  end

  assign frame_active = (state != IDLE);

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      to_cnt          <= '0;
      slot_full       <= 1'b0;
      slot_addr       <= '0;
      slot_data       <= '0;
      reg_addr        <= '0;
      reg_data        <= '0;
      reg_input_valid <= 1'b0;
      frame_error     <= 1'b0;
      cmd_overflow    <= 1'b0;
    end else begin
      reg_input_valid <= emit;
      frame_error     <= abort;
      cmd_overflow    <= done && slot_full && !emit;

      if (emit) begin
        reg_addr <= slot_addr;
        reg_data <= slot_data;
      end

      // The slot takes a new frame only if it is empty or draining this cycle.
      if (done && (!slot_full || emit)) begin
        slot_addr <= done_addr;
        slot_data <= done_data;
        slot_full <= 1'b1;
      end else if (emit) begin
        slot_full <= 1'b0;
      end

      if (state == IDLE || byte_ok || abort)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);

      case (state)
        IDLE: begin
          if (byte_ok) begin
            addr_q <= rx_byte;
            if (rx_byte[7])
              state <= D0;
          end
        end
        D0: begin
          if (abort)
            state <= IDLE;
          else if (byte_ok) begin
            lo_q  <= rx_byte;
            state <= D1;
          end
        end
        D1: begin
          if (abort)
            state <= IDLE;
          else if (byte_ok) begin
            hi_q  <= rx_byte;
            state <= D2;
          end
        end
        D2: begin
          if (abort || done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_framer.sv
// tb/tb_spi_cmd_framer.sv - scoreboard bench for spi_cmd_framer
module tb_spi_cmd_framer;

  logic        sysClk = 1'b0;
  logic        sysRst_n;
  logic        spi_cs_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        reg_busy;
  logic [7:0]  reg_addr;
  logic [16:0] reg_data;
  logic        reg_input_valid;
  logic        frame_error;
  logic        cmd_overflow;
  logic        frame_active;

  int n_checks = 0;
  int n_pass   = 0;
  int st_cnt   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int exp_fe   = 0;
  int exp_ov   = 0;
  int st_mark;
  logic [24:0] exp_q[$];

  always #5 sysClk = ~sysClk;

  spi_cmd_framer dut (
    .sysClk          (sysClk),
    .sysRst_n        (sysRst_n),
    .spi_cs_n        (spi_cs_n),
    .rx_byte         (rx_byte),
    .rx_byte_valid   (rx_byte_valid),
    .reg_busy        (reg_busy),
    .reg_addr        (reg_addr),
    .reg_data        (reg_data),
    .reg_input_valid (reg_input_valid),
    .frame_error     (frame_error),
    .cmd_overflow    (cmd_overflow),
    .frame_active    (frame_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Call at a negedge; byte is captured on the next posedge.
  task automatic send(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(negedge sysClk);
    rx_byte_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      @(negedge sysClk);
    repeat (2) @(negedge sysClk);
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge sysClk) begin
    if (sysRst_n) begin
      if (frame_error)  fe_cnt++;
      if (cmd_overflow) ov_cnt++;
      if (reg_input_valid) begin
        logic [24:0] e;
        st_cnt++;
        if (exp_q.size() == 0)
          check("unexpected_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("reg_addr", {24'd0, reg_addr}, {24'd0, e[24:17]});
          check("reg_data", {15'd0, reg_data}, {15'd0, e[16:0]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sysRst_n = 1'b0; spi_cs_n = 1'b1; rx_byte = '0; rx_byte_valid = 1'b0; reg_busy = 1'b0;
    repeat (3) @(negedge sysClk);
    check("rst_valid", reg_input_valid, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovf", cmd_overflow, 0);
    check("rst_active", frame_active, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_data", reg_data, 0);
    sysRst_n = 1'b1;
    @(negedge sysClk);
    spi_cs_n = 1'b0;
    @(negedge sysClk);

    // T1 read, one-cycle latency
    exp_q.push_back({8'h08, 17'h0});
    send(8'h08);
    check("t1_lat0", reg_input_valid, 0);
    @(negedge sysClk);
    check("t1_lat1", reg_input_valid, 1);
    wait_drain("t1_drain");

    // T2 write
    exp_q.push_back({8'h87, 17'h11234});
    send(8'h87);
    check("t2_active", frame_active, 1);
    send(8'h34); send(8'h12); send(8'h01);
    check("t2_idle", frame_active, 0);
    wait_drain("t2_drain");

    // T3 bad range in B3
    st_mark = st_cnt;
    send(8'h87); send(8'h00); send(8'h00); send(8'h02);
    exp_fe++;
    check("t3_ferr_now", frame_error, 1);
    repeat (3) @(negedge sysClk);
    check("t3_ferr_cnt", fe_cnt, exp_fe);
    check("t3_no_strobe", st_cnt, st_mark);
    check("t3_idle", frame_active, 0);

    // T4 timeout after 1024 idle cycles, then a clean read
    send(8'h8A); send(8'h05);
    repeat (1023) @(negedge sysClk);
    check("t4_before", frame_error, 0);
    check("t4_active", frame_active, 1);
    @(negedge sysClk);
    exp_fe++;
    check("t4_expire", frame_error, 1);
    check("t4_idle", frame_active, 0);
    exp_q.push_back({8'h09, 17'h0});
    send(8'h09);
    wait_drain("t4_drain");

    // Byte arriving on the expiry cycle wins
    exp_q.push_back({8'h8C, 17'h16655});
    send(8'h8C);
    repeat (1023) @(negedge sysClk);
    send(8'h55);
    check("race_no_err", frame_error, 0);
    send(8'h66); send(8'h01);
    wait_drain("race_drain");
    check("race_fe_cnt", fe_cnt, exp_fe);

    // T5 backpressure and overflow
    reg_busy = 1'b1;
    st_mark = st_cnt;
    exp_q.push_back({8'h08, 17'h0});
    send(8'h08);
    send(8'h09);
    exp_ov++;
    check("t5_ovf_now", cmd_overflow, 1);
    repeat (5) @(negedge sysClk);
    check("t5_held", st_cnt, st_mark);
    reg_busy = 1'b0;
    wait_drain("t5_drain");
    check("t5_one_strobe", st_cnt, st_mark + 1);

    // Slot drains on the same edge a new frame completes
    reg_busy = 1'b1;
    exp_q.push_back({8'h0A, 17'h0});
    exp_q.push_back({8'h0B, 17'h0});
    send(8'h0A);
    reg_busy = 1'b0;
    send(8'h0B);
    wait_drain("swap_drain");
    check("swap_no_ovf", ov_cnt, exp_ov);

    // T6 cs_n rise mid-frame
    send(8'h87); send(8'h11);
    spi_cs_n = 1'b1;
    @(negedge sysClk);
    exp_fe++;
    check("t6_cs_abort", frame_error, 1);
    spi_cs_n = 1'b0;
    @(negedge sysClk);

    // cs_n rise coincident with the final byte
    st_mark = st_cnt;
    send(8'h87); send(8'h11); send(8'h22);
    rx_byte = 8'h00; rx_byte_valid = 1'b1; spi_cs_n = 1'b1;
    @(negedge sysClk);
    rx_byte_valid = 1'b0;
    exp_fe++;
    check("cs_final_abort", frame_error, 1);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge sysClk);
    check("cs_final_nocmd", st_cnt, st_mark);
    check("fe_total", fe_cnt, exp_fe);

    // Reset mid-frame with slot full
    reg_busy = 1'b1;
    st_mark = st_cnt;
    send(8'h08); send(8'h87); send(8'h11);
    check("t6r_active", frame_active, 1);
    sysRst_n = 1'b0;
    #1;
    check("t6r_addr", reg_addr, 0);
    check("t6r_data", reg_data, 0);
    check("t6r_active0", frame_active, 0);
    check("t6r_valid", reg_input_valid, 0);
    repeat (2) @(negedge sysClk);
    sysRst_n = 1'b1;
    reg_busy = 1'b0;
    repeat (6) @(negedge sysClk);
    check("t6r_no_strobe", st_cnt, st_mark);
    check("t6r_ferr", frame_error, 0);
    check("ovf_total", ov_cnt, exp_ov);
    check("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
